// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronises and debounces the seven raw game buttons.
// A press is accepted only when exactly one button is stable for the debounce
// window. The clean one-hot vector is then held until the release has also
// been filtered. The block also produces a one-cycle press pulse and the
// encoded button index. Multi-button presses are rejected and waited out.
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int N_BOTOES        = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_brutos,
  output logic [N_BOTOES-1:0] botoes,
  output logic                pulso_jogada,
  output logic [2:0]          codigo_botao,
  output logic                multiplo,
  output logic [2:0]          db_estado
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    FILTRA      = 3'd1,
    PRESSIONADO = 3'd2,
    SOLTA       = 3'd3,
    REJEITA     = 3'd4
  } estado_t;

  estado_t             estado, estado_prox;
  logic [N_BOTOES-1:0] sinc1;
  logic [N_BOTOES-1:0] s;
  logic [N_BOTOES-1:0] candidato, candidato_prox;
  logic [CW-1:0]       cnt, cnt_prox;
  logic [N_BOTOES-1:0] botoes_prox;
  logic                pulso_prox;
  logic [2:0]          codigo_prox;
  logic                multiplo_prox;

  // True when exactly one bit of the vector is set.
  function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

  // Index of the highest set bit; callers only pass one-hot vectors.
  function automatic logic [2:0] codificar(input logic [N_BOTOES-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Two-flop synchroniser; the FSM only ever looks at s.
  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1 <= '0;
      s     <= '0;
    end else begin
      sinc1 <= botoes_brutos;
      s     <= sinc1;
    end
  end

  // State, debounce counter, candidate and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      candidato    <= '0;
      botoes       <= '0;
      pulso_jogada <= 1'b0;
      codigo_botao <= 3'd0;
      multiplo     <= 1'b0;
    end else begin
      estado       <= estado_prox;
      cnt          <= cnt_prox;
      candidato    <= candidato_prox;
      botoes       <= botoes_prox;
      pulso_jogada <= pulso_prox;
      codigo_botao <= codigo_prox;
      multiplo     <= multiplo_prox;
    end
  end

  // Next-state and next-output logic; the pulse is the only non-held output.
  always_comb begin
    estado_prox    = estado;
    cnt_prox       = cnt;
    candidato_prox = candidato;
    botoes_prox    = botoes;
    pulso_prox     = 1'b0;
    codigo_prox    = codigo_botao;
    multiplo_prox  = multiplo;

    case (estado)
      OCIOSO: begin
        if (s != '0) begin
          candidato_prox = s;
          cnt_prox       = '0;
          estado_prox    = FILTRA;
        end else begin
          cnt_prox = '0;
        end
      end

      FILTRA: begin
        if (s != candidato) begin
          // Any change restarts filtering from idle, so glitches never pass.
          cnt_prox    = '0;
          estado_prox = OCIOSO;
        end else if (cnt == CNT_FIM) begin
          cnt_prox = '0;
          if (eh_one_hot(candidato)) begin
            estado_prox = PRESSIONADO;
            botoes_prox = candidato;
            codigo_prox = codificar(candidato);
            pulso_prox  = 1'b1;
          end else begin
            estado_prox   = REJEITA;
            multiplo_prox = 1'b1;
          end
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end

      PRESSIONADO: begin
        // A second button joining the held one also leaves this state.
        if (s != candidato) begin
          cnt_prox    = '0;
          estado_prox = SOLTA;
        end else begin
          cnt_prox = cnt;
        end
      end

      SOLTA: begin
        if (s == candidato) begin
          // Release bounce: back to held, no new pulse.
          cnt_prox    = '0;
          estado_prox = PRESSIONADO;
        end else if (s != '0) begin
          // Some other button still down: require a full release.
          cnt_prox = '0;
        end else if (cnt == CNT_FIM) begin
          cnt_prox    = '0;
          estado_prox = OCIOSO;
          botoes_prox = '0;
          codigo_prox = 3'd0;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end

      REJEITA: begin
        if (s != '0) begin
          cnt_prox = '0;
        end else if (cnt == CNT_FIM) begin
          cnt_prox      = '0;
          estado_prox   = OCIOSO;
          multiplo_prox = 1'b0;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end

      default: begin
        estado_prox    = OCIOSO;
        cnt_prox       = '0;
        candidato_prox = '0;
        botoes_prox    = '0;
        codigo_prox    = 3'd0;
        multiplo_prox  = 1'b0;
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed button scenarios plus random
// press/release segments. The driver steps a reference model and queues the
// expected outputs; an independent monitor pops and compares every cycle.
module tb_condicionador_botoes;

  localparam int D = 4;

  localparam int M_OCIOSO  = 0;
  localparam int M_FILTRA  = 1;
  localparam int M_PRESSIO = 2;
  localparam int M_SOLTA   = 3;
  localparam int M_REJEITA = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] botoes_brutos;
  logic [6:0] botoes;
  logic       pulso_jogada;
  logic [2:0] codigo_botao;
  logic       multiplo;
  logic [2:0] db_estado;

  typedef struct {
    int         cyc;
    logic [6:0] botoes;
    logic       pulso;
    logic [2:0] codigo;
    logic       multiplo;
    logic [2:0] estado;
  } esperado_t;

  esperado_t fila[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int dut_pulsos = 0;
  int ultimo_pulso = -1;
  int ultimo_solta = -1;

  // Reference model state
  logic [6:0] m_ff1 = '0;
  logic [6:0] m_s = '0;
  logic [6:0] m_cand = '0;
  int         m_cnt = 0;
  int         m_modo = M_OCIOSO;
  logic [6:0] m_botoes = '0;
  logic       m_pulso = 1'b0;
  logic [2:0] m_codigo = 3'd0;
  logic       m_mult = 1'b0;

  condicionador_botoes #(
    .DEBOUNCE_CYCLES(D),
    .N_BOTOES(7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .botoes_brutos(botoes_brutos),
    .botoes(botoes),
    .pulso_jogada(pulso_jogada),
    .codigo_botao(codigo_botao),
    .multiplo(multiplo),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] indice(input logic [6:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // One clock edge of the behavioural model, written from the press/release rules.
  task automatic model_step(input logic [6:0] raw, input logic rst);
    if (rst) begin
      m_ff1 = '0; m_s = '0; m_cand = '0; m_cnt = 0; m_modo = M_OCIOSO;
      m_botoes = '0; m_pulso = 1'b0; m_codigo = 3'd0; m_mult = 1'b0;
    end else begin
      m_pulso = 1'b0;
      case (m_modo)
        M_OCIOSO: begin
          if (m_s != 7'd0) begin
            m_cand = m_s; m_cnt = 0; m_modo = M_FILTRA;
          end
        end
        M_FILTRA: begin
          if (m_s != m_cand) begin
            m_modo = M_OCIOSO;
          end else if (m_cnt == D - 1) begin
            m_cnt = 0;
            if ($countones(m_cand) == 1) begin
              m_modo = M_PRESSIO; m_botoes = m_cand;
              m_codigo = indice(m_cand); m_pulso = 1'b1;
            end else begin
              m_modo = M_REJEITA; m_mult = 1'b1;
            end
          end else begin
            m_cnt++;
          end
        end
        M_PRESSIO: begin
          if (m_s != m_cand) begin
            m_modo = M_SOLTA; m_cnt = 0;
          end
        end
        M_SOLTA: begin
          if (m_s == m_cand) begin
            m_modo = M_PRESSIO; m_cnt = 0;
          end else if (m_s != 7'd0) begin
            m_cnt = 0;
          end else if (m_cnt == D - 1) begin
            m_modo = M_OCIOSO; m_botoes = '0; m_codigo = 3'd0; m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        M_REJEITA: begin
          if (m_s != 7'd0) begin
            m_cnt = 0;
          end else if (m_cnt == D - 1) begin
            m_modo = M_OCIOSO; m_mult = 1'b0; m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        default: m_modo = M_OCIOSO;
      endcase
      m_s   = m_ff1;
      m_ff1 = raw;
    end
  endtask

  task automatic apply(input logic [6:0] raw, input logic rst);
    esperado_t e;
    @(negedge clock);
    botoes_brutos = raw;
    reset = rst;
    @(posedge clock);
    model_step(raw, rst);
    cyc++;
    e.cyc = cyc; e.botoes = m_botoes; e.pulso = m_pulso;
    e.codigo = m_codigo; e.multiplo = m_mult; e.estado = 3'(m_modo);
    fila.push_back(e);
  endtask

  task automatic aplica_n(input logic [6:0] raw, input int n);
    for (int i = 0; i < n; i++) apply(raw, 1'b0);
  endtask

  task automatic check(input string nome, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
    end
  endtask

  function automatic int saidas_dut();
    return int'({botoes, pulso_jogada, codigo_botao, multiplo, db_estado});
  endfunction

  // Monitor: compares each presented output against the queued expectation.
  initial begin : monitor
    esperado_t e;
    logic [6:0] b_ant;
    b_ant = '0;
    forever begin
      @(posedge clock);
      #1;
      if (fila.size() > 0) begin
        e = fila.pop_front();
        n_vec++;
        if (botoes !== e.botoes || pulso_jogada !== e.pulso || codigo_botao !== e.codigo ||
            multiplo !== e.multiplo || db_estado !== e.estado) begin
          n_err++;
          $display("FAIL saidas cyc=%0d: got botoes=%b pulso=%b codigo=%0d multiplo=%b estado=%0d, expected botoes=%b pulso=%b codigo=%0d multiplo=%b estado=%0d",
                   e.cyc, botoes, pulso_jogada, codigo_botao, multiplo, db_estado,
                   e.botoes, e.pulso, e.codigo, e.multiplo, e.estado);
        end
        n_vec++;
        if ((botoes != 7'd0 && $countones(botoes) != 1) || (pulso_jogada && botoes == 7'd0)) begin
          n_err++;
          $display("FAIL invariante cyc=%0d: got botoes=%b pulso=%b, expected one-hot or zero with pulse only when held",
                   e.cyc, botoes, pulso_jogada);
        end
        if (pulso_jogada === 1'b1) begin
          dut_pulsos++;
          ultimo_pulso = e.cyc;
        end
        if (b_ant != 7'd0 && botoes == 7'd0) ultimo_solta = e.cyc;
        b_ant = botoes;
      end
    end
  end

  initial begin : estimulo
    int         inicio;
    int         p0;
    int         len;
    int         tipo;
    logic       rst_seg;
    logic [6:0] v;

    reset = 1'b1;
    botoes_brutos = 7'd0;

    // Reset state
    for (int i = 0; i < 3; i++) apply(7'd0, 1'b1);
    #2;
    check("reset_saidas", saidas_dut(), 0);
    aplica_n(7'd0, 2);

    // 1: single press of bit2, then release
    p0 = dut_pulsos;
    inicio = cyc + 1;
    aplica_n(7'b0000100, 12);
    #2;
    check("c1_latencia_pulso", ultimo_pulso, inicio + D + 2);
    check("c1_pulsos", dut_pulsos - p0, 1);
    check("c1_codigo", int'(codigo_botao), 2);
    check("c1_botoes", int'(botoes), 4);
    inicio = cyc + 1;
    aplica_n(7'd0, 12);
    #2;
    check("c1_latencia_solta", ultimo_solta, inicio + D + 2);
    check("c1_botoes_zero", int'(botoes), 0);

    // 2: bit5 bouncing every 2 cycles, then steady
    p0 = dut_pulsos;
    for (int i = 0; i < 20; i++) apply((((i / 2) % 2) == 0) ? 7'b0100000 : 7'd0, 1'b0);
    #2;
    check("c2_sem_pulso_bounce", dut_pulsos - p0, 0);
    inicio = cyc + 1;
    aplica_n(7'b0100000, 12);
    #2;
    check("c2_pulsos", dut_pulsos - p0, 1);
    check("c2_latencia_pulso", ultimo_pulso, inicio + D + 2);
    check("c2_codigo", int'(codigo_botao), 5);
    aplica_n(7'd0, 12);

    // 3: bits 0 and 3 together are rejected, then bit1 is accepted
    p0 = dut_pulsos;
    aplica_n(7'b0001001, 12);
    #2;
    check("c3_multiplo", int'(multiplo), 1);
    check("c3_botoes_zero", int'(botoes), 0);
    check("c3_sem_pulso", dut_pulsos - p0, 0);
    aplica_n(7'd0, 12);
    #2;
    check("c3_multiplo_limpo", int'(multiplo), 0);
    aplica_n(7'b0000010, 12);
    #2;
    check("c3_pulso_bit1", dut_pulsos - p0, 1);
    check("c3_codigo", int'(codigo_botao), 1);
    aplica_n(7'd0, 12);

    // 4: bit6 held, release with a one-cycle re-press glitch
    p0 = dut_pulsos;
    aplica_n(7'b1000000, 12);
    aplica_n(7'd0, 2);
    apply(7'b1000000, 1'b0);
    aplica_n(7'd0, 2);
    #2;
    check("c4_botoes_mantido", int'(botoes), 64);
    aplica_n(7'd0, 10);
    #2;
    check("c4_pulsos", dut_pulsos - p0, 1);
    check("c4_botoes_zero", int'(botoes), 0);

    // 5: bit4 held, bit0 joins, both released
    p0 = dut_pulsos;
    aplica_n(7'b0010000, 12);
    aplica_n(7'b0010001, 10);
    #2;
    check("c5_botoes_mantido", int'(botoes), 16);
    aplica_n(7'd0, 12);
    #2;
    check("c5_pulsos", dut_pulsos - p0, 1);
    check("c5_botoes_zero", int'(botoes), 0);

    // 6: reset while bit3 is held, bit3 kept held afterwards
    p0 = dut_pulsos;
    aplica_n(7'b0001000, 12);
    apply(7'b0001000, 1'b1);
    #2;
    check("c6_reset_saidas", saidas_dut(), 0);
    inicio = cyc + 1;
    aplica_n(7'b0001000, 12);
    #2;
    check("c6_pulsos", dut_pulsos - p0, 2);
    check("c6_latencia_pulso", ultimo_pulso, inicio + D + 2);
    aplica_n(7'd0, 12);

    // Random segments of idle, single, and multi-button levels with rare resets
    for (int seg = 0; seg < 70; seg++) begin
      len  = $urandom_range(1, 10);
      tipo = $urandom_range(0, 9);
      if (tipo < 3) v = 7'd0;
      else if (tipo < 8) v = 7'b0000001 << $urandom_range(0, 6);
      else v = 7'($urandom_range(1, 127));
      rst_seg = ($urandom_range(0, 39) == 0);
      for (int j = 0; j < len; j++) apply(v, (j == 0) ? rst_seg : 1'b0);
    end
    aplica_n(7'd0, 12);
    #2;
    check("fila_vazia", fila.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
